ahb_sram_slave: RTL and testbench

- AHB-Lite slave with on-chip word-addressed memory.
- Sits directly downstream of the bus arbiter/decoder: consumes one slave's hsel bit plus the shared address, control and write-data buses, and returns hready, hresp and hrdata to the arbiter's per-slave inputs.
- Supports programmable wait states, byte/halfword/word accesses and pipelined back-to-back transfers.

---
 rtl/ahb_sram_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave -- AHB-Lite slave in front of an on-chip word-addressed SRAM.
//
// Accepts pipelined single-beat transfers (byte, halfword or word), inserts
// WAIT_STATES low-hready cycles into every OKAY data phase, and writes memory
// on the edge that ends the data phase. A read that enters its final data
// cycle on the same edge as a completing write to the same word sees the
// merged new data.
//
// Optional feature macro: AHB_SRAM_ERROR_EN
//   defined   : illegal accesses (size > word, misaligned, or offset beyond the
//               memory) get a two-cycle ERROR response and never touch memory.
//   undefined : illegal accesses complete as OKAY; writes are discarded and
//               reads return zero. Out-of-range offsets wrap onto the memory.
//
// Parameters:
//   ADDR_BASE   first byte address decoded to this slave (word aligned)
//   MEM_WORDS   memory depth in 32-bit words (power of two, >= 4)
//   WAIT_STATES low-hready cycles per OKAY data phase (0..15)
//
// Ports:
//   hclk        in   bus clock
//   hreset      in   asynchronous active-low reset
//   hsel        in   slave select from the decoder
//   haddr       in   [31:0] address-phase address
//   htrans      in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   hwrite      in   1 = write
//   hsize       in   [2:0] 000 byte, 001 half, 010 word
//   hburst      in   [2:0] burst type (no effect)
//   hmastlock   in   locked transfer (no effect)
//   hwdata      in   [31:0] write data, valid during the data phase
//   hready_in   in   bus-level hready
//   hready_out  out  this slave's hready
//   hresp       out  [1:0] 00 OKAY, 01 ERROR
//   hrdata      out  [31:0] read data

module ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    case (size)
      3'b000:  lane_mask = 4'b0001 << off;
      3'b001:  lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replace the selected byte lanes of old_w with those of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    for (int i = 0; i < 4; i++) begin
      lane_merge[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;

  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_off;
  logic [2:0]         r_size;
  logic               r_write;
  logic               r_illegal;
  logic [31:0]        r_hrdata;
  logic [31:0]        r_mem [MEM_WORDS];

  logic               w_can_accept;
  logic               w_accept;
  logic [31:0]        w_offset;
  logic [IDX_W-1:0]   w_idx;
  logic               w_bad_size;
  logic               w_misalign;
  logic               w_illegal;
  logic               w_wr_now;
  logic [31:0]        w_wr_word;
  logic               w_ld;
  logic [IDX_W-1:0]   w_ld_idx;
  logic               w_ld_illegal;
  logic [31:0]        w_ld_data;
  logic               w_unused;

  // ---- address phase decode ----
  // WAIT and ERR1 hold the bus, so an address phase seen there is never taken.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept     = hsel & htrans[1] & hready_in & w_can_accept;
  assign w_offset     = haddr - ADDR_BASE;
  assign w_idx        = w_offset[IDX_W+1:2];
  assign w_bad_size   = (hsize > 3'b010);
  assign w_misalign   = ((hsize == 3'b001) && haddr[0]) ||
                        ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

`ifdef AHB_SRAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
  assign w_illegal = w_bad_size | w_misalign | (w_offset >= MEM_BYTES);
`else
  localparam bit ERR_EN = 1'b0;
  // Out-of-range offsets simply wrap through the truncated word index.
  assign w_illegal = w_bad_size | w_misalign;
`endif

  assign w_unused = ^{hburst, hmastlock, htrans[0], w_offset};

  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_idx     <= w_idx;
      r_off     <= haddr[1:0];
      r_size    <= hsize;
      r_write   <= hwrite;
      r_illegal <= w_illegal;
    end
  end

  // ---- control FSM ----
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd1) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: w_state_nxt = S_IDLE;
    endcase
    // A pipelined accept overrides the fall-back to IDLE from DONE/ERR2.
    if (w_accept) begin
      if (ERR_EN && w_illegal) begin
        w_state_nxt = S_ERR1;
      end else if (WS == 4'd0) begin
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = WS;
      end
    end
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (r_state)
      S_WAIT:  hready_out = 1'b0;
      S_ERR1: begin
        hready_out = 1'b0;
        hresp      = 2'b01;
      end
      S_ERR2:  hresp = 2'b01;
      default: ;
    endcase
  end

  // ---- data phase: memory write and read-data load ----
  assign w_wr_now  = (r_state == S_DONE) && r_write && !r_illegal;
  assign w_wr_word = lane_merge(r_mem[r_idx], hwdata, lane_mask(r_off, r_size));

  always_ff @(posedge hclk) begin
    if (w_wr_now) r_mem[r_idx] <= w_wr_word;
  end

  // hrdata is loaded on the edge entering DONE for a read. With zero wait
  // states that edge can coincide with a write completing to the same word,
  // so the merged write data is forwarded instead of the stale array word.
  assign w_ld         = (w_state_nxt == S_DONE) &&
                        (w_accept ? !hwrite : ((r_state == S_WAIT) && !r_write));
  assign w_ld_idx     = w_accept ? w_idx : r_idx;
  assign w_ld_illegal = w_accept ? w_illegal : r_illegal;
  assign w_ld_data    = w_ld_illegal                        ? 32'h0 :
                        (w_wr_now && (r_idx == w_ld_idx))   ? w_wr_word :
                                                              r_mem[w_ld_idx];

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset)   r_hrdata <= '0;
    else if (w_ld) r_hrdata <= w_ld_data;
  end

  assign hrdata = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

  localparam int MEMW = 64;
`ifdef AHB_SRAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel_v;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hmastlock;
  logic [2:0]  ho;
  logic [1:0]  hr [3];
  logic [31:0] hd [3];
  logic        hready_bus;

  int n_cmp = 0;
  int n_fail = 0;
  bit cnt_en = 0;
  int burst_tot = 0;
  int burst_low = 0;

  always #5 hclk = ~hclk;

  // Idle slaves drive hready high, so the AND is the bus-level hready.
  assign hready_bus = &ho;

  ahb_sram_slave #(.ADDR_BASE(32'h0), .MEM_WORDS(MEMW), .WAIT_STATES(0)) u_s0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready_in(hready_bus), .hready_out(ho[0]), .hresp(hr[0]),
    .hrdata(hd[0]));
  ahb_sram_slave #(.ADDR_BASE(32'h0), .MEM_WORDS(MEMW), .WAIT_STATES(2)) u_s1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready_in(hready_bus), .hready_out(ho[1]), .hresp(hr[1]),
    .hrdata(hd[1]));
  ahb_sram_slave #(.ADDR_BASE(32'h1000), .MEM_WORDS(MEMW), .WAIT_STATES(3)) u_s2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hwdata(hwdata), .hready_in(hready_bus), .hready_out(ho[2]), .hresp(hr[2]),
    .hrdata(hd[2]));

  function automatic int ws_of(input int s);
    case (s)
      0: ws_of = 0;
      1: ws_of = 2;
      default: ws_of = 3;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int s);
    base_of = (s == 2) ? 32'h1000 : 32'h0;
  endfunction

  // ---------------- transaction-level model ----------------
  // Each accepted transfer owns a data phase of a known length; writes land
  // in the model memory when that phase retires, reads sample the model
  // memory after any transfer retiring on the same edge.
  logic [31:0] mmem   [3][MEMW];
  bit          m_busy [3];
  bit          m_err  [3];
  bit          m_wr   [3];
  bit          m_ill  [3];
  int          m_left [3];
  int          m_idx  [3];
  int          m_first[3];
  int          m_nb   [3];
  logic [31:0] m_pend [3];
  logic [31:0] m_hr   [3];

  function automatic bit m_rdy(input int s);
    m_rdy = !m_busy[s] || (m_left[s] == 1);
  endfunction

  task automatic model_step();
    bit          brdy;
    logic [31:0] off;
    bit          ill;
    if (!hreset) begin
      for (int s = 0; s < 3; s++) begin
        m_busy[s] = 0;
        m_hr[s]   = 32'h0;
      end
    end else begin
      brdy = 1;
      for (int s = 0; s < 3; s++) if (!m_rdy(s)) brdy = 0;
      for (int s = 0; s < 3; s++) begin
        if (m_busy[s]) begin
          if (m_left[s] == 1) begin
            if (m_wr[s] && !m_err[s] && !m_ill[s])
              for (int b = 0; b < 4; b++)
                if (b >= m_first[s] && b < m_first[s] + m_nb[s])
                  mmem[s][m_idx[s]][8*b +: 8] = hwdata[8*b +: 8];
            m_busy[s] = 0;
          end else begin
            m_left[s] = m_left[s] - 1;
            if (m_left[s] == 1 && !m_err[s] && !m_wr[s]) m_hr[s] = m_pend[s];
          end
        end
        if (brdy && hsel_v[s] && htrans[1]) begin
          off = haddr - base_of(s);
          ill = (hsize > 3'd2) || (hsize == 3'd1 && (haddr % 2) != 0) ||
                (hsize == 3'd2 && (haddr % 4) != 0);
          if (ERR_EN && off >= 32'(MEMW * 4)) ill = 1;
          m_busy[s]  = 1;
          m_wr[s]    = hwrite;
          m_ill[s]   = ill;
          m_idx[s]   = int'((off / 4) % MEMW);
          m_first[s] = int'(off % 4);
          m_nb[s]    = 1 << hsize;
          if (ERR_EN && ill) begin
            m_err[s]  = 1;
            m_left[s] = 2;
          end else begin
            m_err[s]  = 0;
            m_left[s] = ws_of(s) + 1;
            if (!hwrite) begin
              m_pend[s] = ill ? 32'h0 : mmem[s][m_idx[s]];
              if (m_left[s] == 1) m_hr[s] = m_pend[s];
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge hclk or negedge hreset);
    model_step();
  end

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s slave%0d t=%0t got=%h expected=%h", nm, s, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus burst cycle counting.
  initial forever begin
    @(negedge hclk);
    for (int s = 0; s < 3; s++) begin
      chk("hready_out", s, {31'h0, ho[s]}, {31'h0, m_rdy(s)});
      chk("hresp", s, {30'h0, hr[s]}, (m_busy[s] && m_err[s]) ? 32'h1 : 32'h0);
      if (!(m_busy[s] && !m_err[s] && m_wr[s] && m_left[s] == 1))
        chk("hrdata", s, hd[s], m_hr[s]);
    end
    if (cnt_en) begin
      burst_tot++;
      if (!ho[1]) burst_low++;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [2:0] sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    hsel_v = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = wd;
  endtask

  // Waits for the edge at which the bus is ready, i.e. the current data
  // phase completes and the driven address phase is taken.
  task automatic wait_rdy();
    int   n;
    logic r;
    n = 0;
    do begin
      @(negedge hclk);
      r = hready_bus;
      @(posedge hclk);
      n++;
    end while (!r && n < 40);
    if (!r) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout waiting for hready t=%0t", $time);
    end
    #1;
  endtask

  task automatic step(input logic [2:0] sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    drive(sel, tr, wr, a, sz, wd);
    wait_rdy();
  endtask

  initial begin
    hreset = 1'b0; hburst = 3'b000; hmastlock = 1'b0;
    drive(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hready", 0, {31'h0, ho[0]}, 32'h1);
    chk("rst_hresp", 0, {30'h0, hr[0]}, 32'h0);
    chk("rst_hrdata", 0, hd[0], 32'h0);
    hreset = 1'b1;

    // Write then immediate read of the same word, zero wait states.
    step(3'b001, T_NS, 1'b1, 32'h8, SZ_W, 32'h0);
    step(3'b001, T_NS, 1'b0, 32'h8, SZ_W, 32'hDEADBEEF);
    chk("bypass", 0, hd[0], 32'hDEADBEEF);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    // Byte-lane merge.
    step(3'b001, T_NS, 1'b1, 32'h4, SZ_W, 32'h0);
    step(3'b001, T_NS, 1'b1, 32'h6, SZ_B, 32'h11223344);
    step(3'b001, T_NS, 1'b1, 32'h4, SZ_H, 32'h00AA0000);
    step(3'b001, T_NS, 1'b0, 32'h4, SZ_W, 32'h00005566);
    chk("lane_merge", 0, hd[0], 32'h11AA5566);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    // BUSY while selected, then NONSEQ while unselected: no effect.
    step(3'b001, T_BUSY, 1'b1, 32'h8, SZ_W, 32'h0);
    step(3'b000, T_NS, 1'b1, 32'h8, SZ_W, 32'hFFFFFFFF);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'hFFFFFFFF);
    chk("unsel_hready", 0, {31'h0, ho[0]}, 32'h1);
    step(3'b001, T_NS, 1'b0, 32'h8, SZ_W, 32'h0);
    chk("unsel_data", 0, hd[0], 32'hDEADBEEF);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);

    // Two wait states: fill four words, then a 4-beat INCR read.
    hburst = 3'b011;
    step(3'b010, T_NS, 1'b1, 32'h0, SZ_W, 32'h0);
    step(3'b010, T_SEQ, 1'b1, 32'h4, SZ_W, 32'hB0B00000);
    step(3'b010, T_SEQ, 1'b1, 32'h8, SZ_W, 32'hB0B00001);
    step(3'b010, T_SEQ, 1'b1, 32'hC, SZ_W, 32'hB0B00002);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'hB0B00003);
    step(3'b010, T_NS, 1'b0, 32'h0, SZ_W, 32'h0);
    cnt_en = 1;
    step(3'b010, T_SEQ, 1'b0, 32'h4, SZ_W, 32'h0);
    step(3'b010, T_SEQ, 1'b0, 32'h8, SZ_W, 32'h0);
    step(3'b010, T_SEQ, 1'b0, 32'hC, SZ_W, 32'h0);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    cnt_en = 0;
    hburst = 3'b000;
    chk("burst_cycles", 1, burst_tot, 32'd12);
    chk("burst_low", 1, burst_low, 32'd8);
    chk("burst_last", 1, hd[1], 32'hB0B00003);

    // Offset beyond the memory: wraps without the error feature, errors with it.
    step(3'b010, T_NS, 1'b1, 32'h20, SZ_W, 32'h0);
    step(3'b010, T_NS, 1'b1, 32'h120, SZ_W, 32'h00002020);
    step(3'b010, T_NS, 1'b0, 32'h20, SZ_W, 32'h0BADF00D);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    chk("range_wrap", 1, hd[1], ERR_EN ? 32'h00002020 : 32'h0BADF00D);

    // Reset in the middle of a three-wait-state write drops the write.
    step(3'b100, T_NS, 1'b1, 32'h1010, SZ_W, 32'h0);
    step(3'b100, T_NS, 1'b0, 32'h1010, SZ_W, 32'h12345678);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    chk("pre_rst_data", 2, hd[2], 32'h12345678);
    step(3'b100, T_NS, 1'b1, 32'h1010, SZ_W, 32'h0);
    drive(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'hCAFEF00D);
    @(posedge hclk);
    #3;
    chk("mid_wait_hready", 2, {31'h0, ho[2]}, 32'h0);
    hreset = 1'b0;
    #1;
    chk("rst_async_hready", 2, {31'h0, ho[2]}, 32'h1);
    chk("rst_async_hresp", 2, {30'h0, hr[2]}, 32'h0);
    chk("rst_async_hrdata", 2, hd[2], 32'h0);
    @(posedge hclk);
    #3;
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    step(3'b100, T_NS, 1'b0, 32'h1010, SZ_W, 32'h0);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    chk("write_dropped", 2, hd[2], 32'h12345678);

    // Misaligned halfword write.
    step(3'b001, T_NS, 1'b1, 32'h0, SZ_W, 32'h0);
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'hA5A5A5A5);
    step(3'b001, T_NS, 1'b1, 32'h1, SZ_H, 32'h0);
    drive(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0000BEEF);
    if (ERR_EN) begin
      chk("err1_hready", 0, {31'h0, ho[0]}, 32'h0);
      chk("err1_hresp", 0, {30'h0, hr[0]}, 32'h1);
      @(posedge hclk);
      #1;
      chk("err2_hready", 0, {31'h0, ho[0]}, 32'h1);
      chk("err2_hresp", 0, {30'h0, hr[0]}, 32'h1);
    end else begin
      chk("ill_hready", 0, {31'h0, ho[0]}, 32'h1);
      chk("ill_hresp", 0, {30'h0, hr[0]}, 32'h0);
    end
    wait_rdy();
    step(3'b001, T_NS, 1'b0, 32'h0, SZ_W, 32'h0);
    chk("ill_no_write", 0, hd[0], 32'hA5A5A5A5);
    if (!ERR_EN) begin
      step(3'b001, T_NS, 1'b0, 32'h1, SZ_H, 32'h0);
      chk("ill_read_zero", 0, hd[0], 32'h0);
    end
    step(3'b000, T_IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
    repeat (2) @(posedge hclk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
